// File: rtl/rll27_pkg.sv
// RLL(2,7) encoder shared definitions: code table, prefix parser state,
// per-bit parse step and flush padding.
package rll27_pkg;

  typedef logic [7:0] cw_t;   // codeword, left-aligned (MSB emitted first)
  typedef logic [3:0] len_t;  // codeword length in channel bits

  typedef enum logic [2:0] {PFX_E, PFX_0, PFX_1, PFX_00, PFX_01, PFX_001} pfx_t;
  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  localparam cw_t CW_10   = 8'b0100_0000;
  localparam cw_t CW_11   = 8'b1000_0000;
  localparam cw_t CW_000  = 8'b0001_0000;
  localparam cw_t CW_010  = 8'b1001_0000;
  localparam cw_t CW_011  = 8'b0010_0000;
  localparam cw_t CW_0010 = 8'b0010_0100;
  localparam cw_t CW_0011 = 8'b0000_1000;

  localparam len_t LEN4 = 4'd4;
  localparam len_t LEN6 = 4'd6;
  localparam len_t LEN8 = 4'd8;

  typedef struct packed {
    logic hit;   // a complete data word was recognised
    cw_t  cw;
    len_t len;
    pfx_t nxt;   // prefix state after this step
  } parse_t;

  // Append one data bit to the current prefix.
  function automatic parse_t parse_bit(pfx_t p, logic b);
    parse_t r;
    r.hit = 1'b0;
    r.cw  = '0;
    r.len = '0;
    r.nxt = PFX_E;
    case (p)
      PFX_E:   r.nxt = b ? PFX_1 : PFX_0;
      PFX_0:   r.nxt = b ? PFX_01 : PFX_00;
      PFX_1:   begin r.hit = 1'b1; r.cw = b ? CW_11 : CW_10; r.len = LEN4; end
      PFX_00:  if (b) r.nxt = PFX_001;
               else begin r.hit = 1'b1; r.cw = CW_000; r.len = LEN6; end
      PFX_01:  begin r.hit = 1'b1; r.cw = b ? CW_011 : CW_010; r.len = LEN6; end
      PFX_001: begin r.hit = 1'b1; r.cw = b ? CW_0011 : CW_0010; r.len = LEN8; end
      default: ;
    endcase
    return r;
  endfunction

  // Zero-pad a partial word to the shortest legal word; empty prefix -> nothing.
  function automatic parse_t pad_prefix(pfx_t p);
    parse_t r;
    r.hit = 1'b1;
    r.cw  = '0;
    r.len = '0;
    r.nxt = PFX_E;
    case (p)
      PFX_1:          begin r.cw = CW_10;   r.len = LEN4; end
      PFX_0, PFX_00:  begin r.cw = CW_000;  r.len = LEN6; end
      PFX_01:         begin r.cw = CW_010;  r.len = LEN6; end
      PFX_001:        begin r.cw = CW_0010; r.len = LEN8; end
      default:        r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rll27_cell_serializer.sv
// Cell serializer: shifts a pending codeword out one channel bit per cell of
// CELL_CYCLES clocks and drives the NRZI/NRZ line level.
//  pend_valid/pend_cw/pend_len : codeword waiting in the parser's pending reg
//  flushing                    : flush latch, suppresses underrun
//  load                        : pending word taken this edge
//  idle                        : serializer in IDLE
//  chan_bit/chan_strobe/line_level/busy/underrun : line-side outputs
module rll27_cell_serializer
  import rll27_pkg::*;
#(
  parameter int CELL_CYCLES = 5,
  parameter bit NRZI        = 1'b1,
  parameter bit LEVEL_INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pend_valid,
  input  cw_t  pend_cw,
  input  len_t pend_len,
  input  logic flushing,
  output logic load,
  output logic idle,
  output logic chan_bit,
  output logic chan_strobe,
  output logic line_level,
  output logic busy,
  output logic underrun
);

  localparam int CW = (CELL_CYCLES > 1) ? $clog2(CELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CELL_CYCLES - 1);

  ser_state_t     state, state_nxt;
  logic [CW-1:0]  cnt;
  cw_t            sr;
  len_t           left;   // bits still to be emitted from sr

  logic wrap, last_end, emit, emit_bit;

  assign wrap     = (cnt == CNT_LAST);
  assign last_end = (state == S_SHIFT) && wrap && (left == '0);
  // Either the next bit of the current word, or the first bit of the
  // pending word when the last cell ends (seamless chaining).
  assign emit     = (state == S_SHIFT) && wrap && ((left != '0) || pend_valid);
  assign emit_bit = (left != '0) ? sr[7] : pend_cw[7];
  assign load     = pend_valid && ((state == S_IDLE) || last_end);
  assign idle     = (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pend_valid) state_nxt = S_SHIFT;
      S_SHIFT: if (last_end && !pend_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sr          <= '0;
      left        <= '0;
      chan_bit    <= 1'b0;
      chan_strobe <= 1'b0;
      line_level  <= LEVEL_INIT;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      chan_strobe <= 1'b0;
      underrun    <= 1'b0;
      if (state == S_IDLE) begin
        if (pend_valid) begin
          // Park the counter at its wrap value so the first cell opens on
          // the following edge.
          sr   <= pend_cw;
          left <= pend_len;
          cnt  <= CNT_LAST;
        end
      end else if (!wrap) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
        if (emit) begin
          chan_bit    <= emit_bit;
          chan_strobe <= 1'b1;
          busy        <= 1'b1;
          line_level  <= NRZI ? (line_level ^ emit_bit) : emit_bit;
          if (left != '0) begin
            sr   <= sr << 1;
            left <= left - 4'd1;
          end else begin
            sr   <= pend_cw << 1;
            left <= pend_len - 4'd1;
          end
        end else begin
          chan_bit <= 1'b0;
          busy     <= 1'b0;
          underrun <= !flushing;
        end
      end
    end
  end

endmodule

// File: rtl/rll27_stream_encoder.sv
// RLL(2,7) rate-1/2 stream encoder. Serial data in over valid/ready, parsed
// into variable-length words, serialized as channel cells with NRZI/NRZ out.
//  clk, rst_n          : clock, async active-low reset
//  in_valid/in_bit     : data bit, MSB-first
//  in_ready            : bit accepted when in_valid & in_ready
//  flush               : pulse, terminates stream and pads partial word
//  chan_bit/chan_strobe: channel bit per cell, strobe on first cycle of cell
//  line_level          : encoded line output
//  busy                : codeword being emitted
//  underrun            : codeword ended with nothing pending, not flushing
module rll27_stream_encoder
  import rll27_pkg::*;
#(
  parameter int CELL_CYCLES = 5,
  parameter bit NRZI        = 1'b1,
  parameter bit LEVEL_INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  input  logic flush,
  output logic chan_bit,
  output logic chan_strobe,
  output logic line_level,
  output logic busy,
  output logic underrun
);

  pfx_t   pfx;
  logic   pend_valid;
  cw_t    pend_cw;
  len_t   pend_len;
  logic   flush_lat;
  logic   accept, load, ser_idle;
  parse_t pr, pd;

  // Ready is purely registered state, so in_valid never loops back into it.
  assign in_ready = !pend_valid && !flush_lat;
  assign accept   = in_valid && in_ready;
  assign pr       = parse_bit(pfx, in_bit);
  assign pd       = pad_prefix(pfx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfx        <= PFX_E;
      pend_valid <= 1'b0;
      pend_cw    <= '0;
      pend_len   <= '0;
      flush_lat  <= 1'b0;
    end else begin
      // load and accept are mutually exclusive: load needs pend_valid,
      // accept needs it clear.
      if (load) pend_valid <= 1'b0;

      if (accept) begin
        pfx <= pr.nxt;
        if (pr.hit) begin
          pend_valid <= 1'b1;
          pend_cw    <= pr.cw;
          pend_len   <= pr.len;
        end
      end else if (flush_lat && !pend_valid && pd.hit) begin
        pfx        <= pd.nxt;
        pend_valid <= 1'b1;
        pend_cw    <= pd.cw;
        pend_len   <= pd.len;
      end

      if (flush)
        flush_lat <= 1'b1;
      else if (flush_lat && ser_idle && !pend_valid && pfx == PFX_E)
        flush_lat <= 1'b0;
    end
  end

  rll27_cell_serializer #(
    .CELL_CYCLES(CELL_CYCLES),
    .NRZI       (NRZI),
    .LEVEL_INIT (LEVEL_INIT)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .pend_valid (pend_valid),
    .pend_cw    (pend_cw),
    .pend_len   (pend_len),
    .flushing   (flush_lat),
    .load       (load),
    .idle       (ser_idle),
    .chan_bit   (chan_bit),
    .chan_strobe(chan_strobe),
    .line_level (line_level),
    .busy       (busy),
    .underrun   (underrun)
  );

endmodule
